// File: rtl/uart_frame_rx_pkg.sv
// Shared constants for the framed UART receiver: frame delimiters, size
// limits and the receiver FSM state encoding.
package uart_frame_rx_pkg;

    localparam logic [7:0] FRAME_HDR = 8'h55;
    localparam logic [7:0] FRAME_CR  = 8'h0D;
    localparam logic [7:0] FRAME_LF  = 8'h0A;

    localparam int MIN_FRAME_BYTES        = 4;
    localparam int DEFAULT_MAX_BYTES      = 11;
    localparam int DEFAULT_TIMEOUT_CYCLES = 100000;

    // Receiver FSM states
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;  // hunting for the header byte
    localparam state_t ST_COLLECT = 2'd1;  // accumulating frame bytes
    localparam state_t ST_HOLD    = 2'd2;  // complete frame presented to consumer

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte idle timer. Counts enabled cycles since the last restart and
// flags expiry on the TIMEOUT_CYCLES-th consecutive idle cycle.
module uart_frame_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic restart,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Next count: restart wins, otherwise advance while enabled and not saturated
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_d = cnt_q + {{(TW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // A byte arriving in the same cycle masks expiry
    assign expired = enable && !restart && (cnt_q == LAST);

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_frame_rx.sv
// Framed UART receiver: hunts for a 0x55 header, collects bytes until a
// CR LF terminator (minimum 4 bytes), presents the frame left-aligned and
// holds it until the consumer acknowledges. Oversize and idle-timeout
// frames are discarded with a frame_err pulse. receive_data_bytes is 4 bits
// wide, so MAX_BYTES must stay at or below 15.
module uart_frame_rx
    import uart_frame_rx_pkg::*;
#(
    parameter int MAX_BYTES      = DEFAULT_MAX_BYTES,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             rx_byte,
    input  logic                   rx_valid,
    output logic [MAX_BYTES*8-1:0] receive_data,
    output logic [3:0]             receive_data_bytes,
    output logic                   RX_interrupt,
    input  logic                   RX_interrupt_clear,
    output logic                   frame_err,
    output logic                   overrun
);

    localparam int DW = MAX_BYTES * 8;

    state_t          state_q, state_d;
    logic [3:0]      count_q, count_d;
    logic [7:0]      prev_q, prev_d;
    logic [DW-1:0]   buf_q, buf_d;
    logic [DW-1:0]   data_q, data_d;
    logic [3:0]      bytes_q, bytes_d;
    logic            irq_q, irq_d;
    logic            ferr_q, ferr_d;
    logic            ovr_q, ovr_d;

    logic [3:0]      count_inc_s;
    logic [DW-1:0]   buf_wr_s;
    logic            term_s;
    logic            timer_en_s;
    logic            timer_restart_s;
    logic            timer_expired_s;

    assign count_inc_s     = count_q + 4'd1;
    assign term_s          = (rx_byte == FRAME_LF) && (prev_q == FRAME_CR) &&
                             (count_inc_s >= 4'(MIN_FRAME_BYTES));
    assign timer_en_s      = (state_q == ST_COLLECT);
    assign timer_restart_s = rx_valid || (state_q != ST_COLLECT);

    uart_frame_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .enable  (timer_en_s),
        .restart (timer_restart_s),
        .expired (timer_expired_s)
    );

    // Assembly buffer with the incoming byte placed at slot count_q (byte 0 = MSB)
    always_comb begin
        buf_wr_s = buf_q;
        for (int k = 0; k < MAX_BYTES; k++) begin
            if (count_q == 4'(k)) begin
                buf_wr_s[DW-1-8*k -: 8] = rx_byte;
            end else begin
                buf_wr_s[DW-1-8*k -: 8] = buf_q[DW-1-8*k -: 8];
            end
        end
    end

    // Frame FSM: header hunt, accumulation, termination/discard and hand-off
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        prev_d  = prev_q;
        buf_d   = buf_q;
        data_d  = data_q;
        bytes_d = bytes_q;
        irq_d   = irq_q;
        ferr_d  = 1'b0;
        // Acknowledge always clears the sticky overrun; a HOLD drop re-sets it below
        if (RX_interrupt_clear) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_valid && (rx_byte == FRAME_HDR)) begin
                    state_d = ST_COLLECT;
                    buf_d   = {FRAME_HDR, {(DW-8){1'b0}}};
                    count_d = 4'd1;
                    prev_d  = FRAME_HDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_COLLECT: begin
                if (rx_valid) begin
                    if (term_s) begin
                        state_d = ST_HOLD;
                        data_d  = buf_wr_s;
                        bytes_d = count_inc_s;
                        irq_d   = 1'b1;
                        count_d = 4'd0;
                    end else if (count_inc_s == 4'(MAX_BYTES)) begin
                        state_d = ST_IDLE;
                        ferr_d  = 1'b1;
                        count_d = 4'd0;
                    end else begin
                        buf_d   = buf_wr_s;
                        count_d = count_inc_s;
                        prev_d  = rx_byte;
                    end
                end else if (timer_expired_s) begin
                    state_d = ST_IDLE;
                    ferr_d  = 1'b1;
                    count_d = 4'd0;
                end else begin
                    state_d = ST_COLLECT;
                end
            end

            ST_HOLD: begin
                if (RX_interrupt_clear) begin
                    irq_d = 1'b0;
                    // A byte arriving with the acknowledge is judged as in IDLE
                    if (rx_valid && (rx_byte == FRAME_HDR)) begin
                        state_d = ST_COLLECT;
                        buf_d   = {FRAME_HDR, {(DW-8){1'b0}}};
                        count_d = 4'd1;
                        prev_d  = FRAME_HDR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (rx_valid) begin
                    ovr_d = 1'b1;
                end else begin
                    state_d = ST_HOLD;
                end
            end

            default: begin
                state_d = ST_IDLE;
                count_d = 4'd0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= 4'd0;
            prev_q  <= 8'h00;
            buf_q   <= '0;
            data_q  <= '0;
            bytes_q <= 4'd0;
            irq_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            prev_q  <= prev_d;
            buf_q   <= buf_d;
            data_q  <= data_d;
            bytes_q <= bytes_d;
            irq_q   <= irq_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign receive_data       = data_q;
    assign receive_data_bytes = bytes_q;
    assign RX_interrupt       = irq_q;
    assign frame_err          = ferr_q;
    assign overrun            = ovr_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: a table of whole-frame vectors plus
// hand-written sequences for timeout, overrun and reset corner cases.
module tb_uart_frame_rx;

    localparam int TMO = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_valid = 1'b0;
    logic [87:0] receive_data;
    logic [3:0]  receive_data_bytes;
    logic        RX_interrupt;
    logic        RX_interrupt_clear = 1'b0;
    logic        frame_err;
    logic        overrun;

    int errors = 0;
    int checks = 0;

    uart_frame_rx #(
        .MAX_BYTES(11),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .rx_byte            (rx_byte),
        .rx_valid           (rx_valid),
        .receive_data       (receive_data),
        .receive_data_bytes (receive_data_bytes),
        .RX_interrupt       (RX_interrupt),
        .RX_interrupt_clear (RX_interrupt_clear),
        .frame_err          (frame_err),
        .overrun            (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          n;
        logic [87:0] b;
        logic        exp_irq;
        logic        exp_ferr;
        logic [87:0] exp_data;
        logic [3:0]  exp_cnt;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge after the byte was sampled
    task automatic send(input logic [7:0] b, input logic clr);
        rx_byte            = b;
        rx_valid           = 1'b1;
        RX_interrupt_clear = clr;
        @(negedge clk);
        rx_valid           = 1'b0;
        RX_interrupt_clear = 1'b0;
        rx_byte            = 8'h00;
    endtask

    task automatic pulse_clear();
        RX_interrupt_clear = 1'b1;
        @(negedge clk);
        RX_interrupt_clear = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_data"},  receive_data, 88'h0);
        check({name, "_bytes"}, {84'h0, receive_data_bytes}, 88'h0);
        check({name, "_irq"},   {87'h0, RX_interrupt}, 88'h0);
        check({name, "_ferr"},  {87'h0, frame_err}, 88'h0);
        check({name, "_ovr"},   {87'h0, overrun}, 88'h0);
    endtask

    initial begin
        int seen;
        logic early;

        vecs[0] = '{"full11", 11, 88'h555D01AABBBBCCDD000D0A, 1'b1, 1'b0, 88'h555D01AABBBBCCDD000D0A, 4'd11};
        vecs[1] = '{"min4", 4, {32'h555D0D0A, 56'h0}, 1'b1, 1'b0, {32'h555D0D0A, 56'h0}, 4'd4};
        vecs[2] = '{"oversize", 11, 88'h5500112233445566778899, 1'b0, 1'b1, 88'h0, 4'd0};
        vecs[3] = '{"short_crlf", 5, {40'h550D0A0D0A, 48'h0}, 1'b1, 1'b0, {40'h550D0A0D0A, 48'h0}, 4'd5};
        vecs[4] = '{"junk_hdr", 6, {48'h112255AA0D0A, 40'h0}, 1'b1, 1'b0, {32'h55AA0D0A, 56'h0}, 4'd4};
        vecs[5] = '{"hdr_as_data", 5, {40'h5555550D0A, 48'h0}, 1'b1, 1'b0, {40'h5555550D0A, 48'h0}, 4'd5};

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                if (k == vecs[i].n - 1) begin
                    check({vecs[i].name, "_irq_pre"}, {87'h0, RX_interrupt}, 88'h0);
                end
                send(vecs[i].b[87-8*k -: 8], 1'b0);
            end
            check({vecs[i].name, "_irq"},  {87'h0, RX_interrupt}, {87'h0, vecs[i].exp_irq});
            check({vecs[i].name, "_ferr"}, {87'h0, frame_err},    {87'h0, vecs[i].exp_ferr});
            if (vecs[i].exp_irq) begin
                check({vecs[i].name, "_data"},  receive_data, vecs[i].exp_data);
                check({vecs[i].name, "_bytes"}, {84'h0, receive_data_bytes}, {84'h0, vecs[i].exp_cnt});
                pulse_clear();
                check({vecs[i].name, "_irq_clr"}, {87'h0, RX_interrupt}, 88'h0);
            end else begin
                @(negedge clk);
                check({vecs[i].name, "_ferr_1cyc"}, {87'h0, frame_err}, 88'h0);
                check({vecs[i].name, "_irq_low"},   {87'h0, RX_interrupt}, 88'h0);
            end
        end

        // Timeout with a restart in the middle, then CR LF alone must be ignored
        send(8'h55, 1'b0);
        send(8'h01, 1'b0);
        early = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (frame_err) early = 1'b1;
        end
        send(8'h02, 1'b0);
        seen = 0;
        for (int c = 1; c <= TMO + 10; c++) begin
            if (frame_err) begin
                if (seen == 0) seen = c - 1;
            end
            if (frame_err || early) break;
            @(negedge clk);
            if (frame_err && seen == 0) seen = c;
        end
        check("tmo_no_early", {87'h0, early}, 88'h0);
        check("tmo_latency", 88'(seen), 88'(TMO));
        @(negedge clk);
        check("tmo_ferr_1cyc", {87'h0, frame_err}, 88'h0);
        send(8'h0D, 1'b0);
        send(8'h0A, 1'b0);
        check("tmo_crlf_noirq", {87'h0, RX_interrupt}, 88'h0);

        // HOLD overrun, then clear+header starts a new frame
        send(8'h55, 1'b0);
        send(8'h5D, 1'b0);
        send(8'h0D, 1'b0);
        send(8'h0A, 1'b0);
        check("hold_irq", {87'h0, RX_interrupt}, 88'h1);
        send(8'h77, 1'b0);
        check("ovr_set", {87'h0, overrun}, 88'h1);
        check("ovr_irq_kept", {87'h0, RX_interrupt}, 88'h1);
        check("ovr_data_kept", receive_data, {32'h555D0D0A, 56'h0});
        send(8'h55, 1'b1);
        check("clrhdr_irq", {87'h0, RX_interrupt}, 88'h0);
        check("clrhdr_ovr", {87'h0, overrun}, 88'h0);
        send(8'h01, 1'b0);
        send(8'h0D, 1'b0);
        send(8'h0A, 1'b0);
        check("clrhdr_frame_irq", {87'h0, RX_interrupt}, 88'h1);
        check("clrhdr_frame_data", receive_data, {32'h55010D0A, 56'h0});
        check("clrhdr_frame_bytes", {84'h0, receive_data_bytes}, 88'd4);
        send(8'h77, 1'b0);
        check("ovr2_set", {87'h0, overrun}, 88'h1);
        pulse_clear();
        check("ovr2_clr", {87'h0, overrun}, 88'h0);
        check("ovr2_irq_clr", {87'h0, RX_interrupt}, 88'h0);

        // Asynchronous reset mid-frame
        send(8'h55, 1'b0);
        send(8'h5D, 1'b0);
        send(8'h01, 1'b0);
        #2 rst = 1'b1;
        #1 check_all_zero("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(8'h0D, 1'b0);
        send(8'h0A, 1'b0);
        check("rst_mid_noirq", {87'h0, RX_interrupt}, 88'h0);

        // Asynchronous reset while a frame is presented
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        send(8'h0D, 1'b0);
        send(8'h0A, 1'b0);
        check("rst_hold_pre", {87'h0, RX_interrupt}, 88'h1);
        #2 rst = 1'b1;
        #1 check_all_zero("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 11, meaning the maximum frame length in bytes including header and terminator.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning the inter-byte idle limit in clk cycles (1 ms at 100 MHz).
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port rx_byte, input, 8 bits: byte from the UART byte receiver.
REQ-006 SHALL have port rx_valid, input, 1 bit: one-cycle strobe qualifying rx_byte.
REQ-007 SHALL have port receive_data, output, 88 bits: assembled frame, left-aligned.
REQ-008 SHALL have port receive_data_bytes, output, 4 bits: byte count of the presented frame.
REQ-009 SHALL have port RX_interrupt, output, 1 bit: frame-ready level.
REQ-010 SHALL have port RX_interrupt_clear, input, 1 bit: consumer acknowledge, one-cycle pulse.
REQ-011 SHALL have port frame_err, output, 1 bit: one-cycle pulse on each discarded frame.
REQ-012 SHALL have port overrun, output, 1 bit: sticky flag for bytes dropped while a frame is pending.

Function
REQ-013 SHALL implement states IDLE (hunt header), COLLECT (accumulate) and HOLD (frame presented).
REQ-014 IDLE: an rx_valid byte equal to 0x55 SHALL be stored as byte 0, set count=1 and enter COLLECT; any other byte SHALL be ignored silently.
REQ-015 COLLECT: each rx_valid byte SHALL be stored at index count, with byte k occupying receive_data[87-8k:80-8k], and count SHALL increment.
REQ-016 Byte 0x55 inside COLLECT SHALL be treated as data; there is no resynchronisation.
REQ-017 A frame SHALL terminate when the accepted byte is 0x0A, the previous byte is 0x0D, and the new count is at least 4.
REQ-018 On termination, the state SHALL enter HOLD, and RX_interrupt SHALL be 1 and receive_data_bytes SHALL equal count from the next cycle.
REQ-019 Unused low bytes of receive_data SHALL read 0; the assembly buffer SHALL be zeroed on entry to COLLECT.
REQ-020 If count reaches MAX_BYTES without termination, the frame SHALL be discarded, frame_err SHALL pulse for one cycle, and the state SHALL return to IDLE.
REQ-021 If no rx_valid arrives for TIMEOUT_CYCLES consecutive cycles in COLLECT, the frame SHALL be discarded, frame_err SHALL pulse, and the state SHALL return to IDLE.
REQ-022 The timeout counter SHALL restart on every accepted byte.
REQ-023 HOLD: receive_data, receive_data_bytes and RX_interrupt SHALL stay stable until RX_interrupt_clear is sampled high.
REQ-024 HOLD: an rx_valid byte without a clear SHALL be dropped and SHALL set overrun.
REQ-025 RX_interrupt_clear with rx_valid in the same HOLD cycle SHALL deassert RX_interrupt the next cycle and process the byte as IDLE would; overrun SHALL NOT be set.
REQ-026 RX_interrupt_clear outside HOLD SHALL have no effect, except that it SHALL clear overrun.
REQ-027 RX_interrupt_clear in HOLD SHALL also clear overrun; a drop in the same cycle takes priority and leaves overrun set.
REQ-028 Minimum latency from the 0x0A strobe to RX_interrupt SHALL be 1 cycle.

Reset
REQ-029 Asserting rst SHALL immediately force the state to IDLE, receive_data=0, receive_data_bytes=0, RX_interrupt=0, frame_err=0, overrun=0, count=0 and timer=0, including mid-frame and in HOLD.
REQ-030 After rst deasserts, the first accepted byte SHALL be evaluated in IDLE.

Structure
REQ-031 A shared package SHALL hold FRAME_HDR=0x55, FRAME_CR=0x0D, FRAME_LF=0x0A, MIN_FRAME_BYTES=4, the default MAX_BYTES, and the state enumeration.
REQ-032 One sub-module, uart_frame_timer, SHALL implement the inter-byte timeout counter (inputs clk, rst, enable, restart; output expired).

Verification
REQ-033 Bytes 55 5D 01 AA BB BB CC DD 00 0D 0A -> one cycle after 0A, RX_interrupt=1, receive_data=88'h555D01AABBBBCCDD000D0A, receive_data_bytes=11.
REQ-034 Bytes 55 5D 0D 0A -> receive_data=88'h555D0D0A followed by 56 zero bits, receive_data_bytes=4; then a clear pulse -> RX_interrupt=0 next cycle.
REQ-035 Bytes 55 00 11 22 33 44 55 66 77 88 99 -> frame_err single pulse, RX_interrupt stays 0, state IDLE; the next valid frame is accepted.
REQ-036 Bytes 55 01 then TIMEOUT_CYCLES idle cycles -> frame_err pulse; a following 0D 0A alone produces no interrupt.
REQ-037 While in HOLD, byte 0x77 without clear -> overrun=1 and receive_data unchanged; byte 0x55 with clear in the same cycle -> RX_interrupt=0, new frame collection begins, overrun not newly set.
REQ-038 rst pulse after bytes 55 5D 01 -> all outputs 0; subsequent 0D 0A -> no interrupt.
